// File: rtl/demux4_buf_pkg.sv
// Shared sizing for the buffered 1-to-4 demultiplexer and its per-channel FIFOs.
package demux4_buf_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 2;

  typedef logic [1:0] fifo_count_t;

endpackage : demux4_buf_pkg

// File: rtl/demux4_buf_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; one instance per output channel.
module fifo2
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wptr;
  logic             rptr;
  fifo_count_t      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == fifo_count_t'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // A full FIFO never accepts, even with a same-cycle pop, so there is no pass-through path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      if (do_push && !do_pop)      count <= count + 2'd1;
      else if (do_pop && !do_push) count <= count - 2'd1;
    end
  end

endmodule : fifo2

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demux: each beat is steered by in_sel into its channel's 2-entry FIFO.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             busy
);

  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] ch_empty;
  logic [NUM_CH-1:0] ch_push;
  logic [WIDTH-1:0]  ch_rdata [NUM_CH];

  // Readiness depends only on the selected channel, never on in_valid.
  assign in_ready = ~ch_full[in_sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_push[k] = in_valid & in_ready & (in_sel == 2'(k));

    fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (ch_push[k]),
      .wdata (in_data),
      .full  (ch_full[k]),
      .pop   (out_ready[k]),
      .rdata (ch_rdata[k]),
      .empty (ch_empty[k])
    );
  end

  assign out_valid = ~ch_empty;
  assign busy      = |out_valid;
  assign out_data0 = ch_rdata[0];
  assign out_data1 = ch_rdata[1];
  assign out_data2 = ch_rdata[2];
  assign out_data3 = ch_rdata[3];

endmodule : demux4_buf

// File: tb/tb_demux4_buf.sv
// Directed and scoreboarded random checks for the buffered 1-to-4 demultiplexer.
module tb_demux4_buf;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       busy;
  logic [7:0] od [4];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  always_comb begin
    od[0] = out_data0;
    od[1] = out_data1;
    od[2] = out_data2;
    od[3] = out_data3;
  end

  demux4_buf #(.WIDTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [1:0] sel, input logic [7:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 4'h0;
    push_beat(2'd0, 8'h5A);
    push_beat(2'd0, 8'h6B);
    push_beat(2'd1, 8'h7C);
    checks++; if (out_valid !== 4'b0011) $display("[TB] FAIL pre_reset_valid actual=%b required=%b", out_valid, 4'b0011); else passes++;
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000) $display("[TB] FAIL reset_valid actual=%b required=%b", out_valid, 4'b0000); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy actual=%b required=0", busy); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready actual=%b required=1", in_ready); else passes++;
    checks++; if (out_data0 !== 8'h00) $display("[TB] FAIL reset_data0 actual=%h required=00", out_data0); else passes++;
    tick();
    rstn      = 1'b1;
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 4'b0000) $display("[TB] FAIL post_reset_stale actual=%b required=0000", out_valid); else passes++;
    end
  endtask

  task automatic test_basic_route();
    out_ready = 4'hF;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 8'hA5;
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL route_in_ready actual=%b required=1", in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0100) $display("[TB] FAIL route_valid actual=%b required=0100", out_valid); else passes++;
    checks++; if (out_data2 !== 8'hA5) $display("[TB] FAIL route_data2 actual=%h required=a5", out_data2); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL route_busy actual=%b required=1", busy); else passes++;
    tick();
    checks++; if (out_valid !== 4'b0000) $display("[TB] FAIL route_popped actual=%b required=0000", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL route_idle_busy actual=%b required=0", busy); else passes++;
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    push_beat(2'd1, 8'h11);
    push_beat(2'd1, 8'h22);
    in_sel = 2'd1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_sel1 actual=%b required=0", in_ready); else passes++;
    in_sel = 2'd0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_free_sel0 actual=%b required=1", in_ready); else passes++;
    checks++; if (out_valid !== 4'b0010 || out_data1 !== 8'h11) $display("[TB] FAIL bp_head1 actual=%b/%h required=0010/11", out_valid, out_data1); else passes++;
    out_ready = 4'hF;
    tick();
    checks++; if (out_valid !== 4'b0010 || out_data1 !== 8'h22) $display("[TB] FAIL bp_second actual=%b/%h required=0010/22", out_valid, out_data1); else passes++;
    tick();
    checks++; if (out_valid !== 4'b0000) $display("[TB] FAIL bp_drained actual=%b required=0000", out_valid); else passes++;
  endtask

  task automatic test_simultaneous();
    out_ready = 4'h0;
    push_beat(2'd3, 8'h01);
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 8'h02;
    out_ready = 4'b1000;
    #1;
    checks++; if (in_ready !== 1'b1 || out_data3 !== 8'h01) $display("[TB] FAIL simul_pre actual=%b/%h required=1/01", in_ready, out_data3); else passes++;
    tick();
    in_valid  = 1'b0;
    out_ready = 4'h0;
    checks++; if (out_valid !== 4'b1000 || out_data3 !== 8'h02) $display("[TB] FAIL simul_head actual=%b/%h required=1000/02", out_valid, out_data3); else passes++;
    out_ready = 4'b1000;
    tick();
    checks++; if (out_valid !== 4'b0000) $display("[TB] FAIL simul_count1 actual=%b required=0000", out_valid); else passes++;
  endtask

  task automatic test_full_pop();
    out_ready = 4'h0;
    push_beat(2'd0, 8'hAA);
    push_beat(2'd0, 8'hBB);
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'hCC;
    out_ready = 4'b0001;
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL fullpop_ready actual=%b required=0", in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0001 || out_data0 !== 8'hBB) $display("[TB] FAIL fullpop_head actual=%b/%h required=0001/bb", out_valid, out_data0); else passes++;
    tick();
    checks++; if (out_valid !== 4'b0000) $display("[TB] FAIL fullpop_no_push actual=%b required=0000", out_valid); else passes++;
  endtask

  task automatic test_random();
    logic [7:0] sb [4][$];
    int   pushed = 0;
    logic hold   = 1'b0;
    logic draining = 1'b0;
    logic exp_ready;
    logic done = 1'b0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      if (draining) begin
        in_valid  = 1'b0;
        out_ready = 4'hF;
      end else begin
        if (!hold) begin
          in_valid = ($urandom_range(0, 99) < 70);
          in_sel   = 2'($urandom_range(0, 3));
          in_data  = 8'($urandom);
        end
        out_ready = 4'($urandom_range(0, 15));
      end
      #1;
      exp_ready = (sb[in_sel].size() != 2);
      checks++; if (in_ready !== exp_ready) $display("[TB] FAIL rnd_in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, exp_ready); else passes++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_valid[k] !== (sb[k].size() != 0))
          $display("[TB] FAIL rnd_valid%0d cyc=%0d actual=%b required=%b", k, cyc, out_valid[k], sb[k].size() != 0);
        else if (sb[k].size() != 0 && od[k] !== sb[k][0])
          $display("[TB] FAIL rnd_data%0d cyc=%0d actual=%h required=%h", k, cyc, od[k], sb[k][0]);
        else passes++;
      end
      for (int k = 0; k < 4; k++)
        if (out_ready[k] && sb[k].size() != 0) void'(sb[k].pop_front());
      if (in_valid && exp_ready) begin
        sb[in_sel].push_back(in_data);
        pushed++;
      end
      hold = in_valid && !exp_ready;
      tick();
      if (pushed >= 10000) draining = 1'b1;
      if (draining && sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 && sb[3].size() == 0)
        done = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (!done) $display("[TB] FAIL rnd_timeout pushed=%0d required=10000", pushed); else passes++;
    checks++; if (out_valid !== 4'b0000 || busy !== 1'b0) $display("[TB] FAIL rnd_final actual=%b/%b required=0000/0", out_valid, busy); else passes++;
  endtask

  initial begin
    rstn      = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    #1;
    checks++; if (out_valid !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL init_reset actual=%b/%b/%b required=0000/0/1", out_valid, busy, in_ready); else passes++;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_basic_route();
    test_backpressure();
    test_simultaneous();
    test_full_pop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_demux4_buf
